// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared types and helpers for the FIFO burst-read controller.
//   - rd_state_e     : controller FSM state (IDLE, READ)
//   - OBUF_DEPTH_DEF : default depth of the output buffer
//   - level_t        : 9-bit FIFO fill level (0..256)
//   - fifo_level()   : fill level from the FIFO full flag and usedw
//   Optional feature macro used by the top: FIFO_RD_TIMEOUT_EN.
package fifo_rd_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_e;

   localparam int OBUF_DEPTH_DEF = 4;

   typedef logic [8:0] level_t;

   // usedw wraps to 0 when the 256-entry FIFO is full, so the full flag
   // supplies the ninth bit.
   function automatic level_t fifo_level(input logic full, input logic [7:0] usedw);
      return full ? 9'd256 : {1'b0, usedw};
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
//   Small circular buffer between the FIFO read port and the output stream.
//   The head entry is presented on registered outputs (head_valid/head_data).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data at the tail this cycle
//     push_data   : data to write
//     pop         : consumer accepts the head (ignored when head_valid=0)
//     occ         : number of stored entries, head included
//     head_valid  : registered, high when occ != 0
//     head_data   : registered head entry
//   Handshake: the head leaves the buffer on a cycle with head_valid && pop;
//   head_data is unchanged while head_valid && !pop. push must not be issued
//   when the buffer is full (the caller's credit logic prevents it).
module rd_skid_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   occ,
   output logic                     head_valid,
   output logic [DATA_W-1:0]        head_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     rd_ptr_nxt;
   logic [OW-1:0]     occ_nxt;
   logic [DATA_W-1:0] head_nxt;
   logic              do_pop;

   assign do_pop = pop && head_valid;

   always_comb begin
      rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
      occ_nxt    = occ + OW'(push) - OW'(do_pop);
      // When the new head is the entry being written right now, bypass the
      // array so the output register sees it in the same cycle.
      if (push && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = push_data;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr     <= rd_ptr_nxt;
         occ        <= occ_nxt;
         head_valid <= (occ_nxt != '0);
         if (occ_nxt != '0) begin
            head_data <= head_nxt;
         end
      end
   end

endmodule

// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd
//   Read-side controller for a 256x8 single-clock FIFO (normal mode,
//   1-cycle read latency). Waits until the fill level reaches BURST_LEN,
//   then drains BURST_LEN words and streams them out on m_data/m_valid.
//   Optional macro FIFO_RD_TIMEOUT_EN: a residue below the threshold that
//   sits untouched for TIMEOUT_CYC cycles is drained as a partial burst.
//   Ports:
//     sys_clk, sys_rst_n : clock, asynchronous active-low reset
//     fifo_q             : FIFO read data, valid the cycle after fifo_rdreq
//     fifo_empty         : FIFO empty flag
//     fifo_full          : FIFO full flag
//     fifo_usedw         : FIFO fill count (wraps to 0 when full)
//     fifo_rdreq         : FIFO read request (combinational)
//     m_data, m_valid    : output stream, registered
//     m_ready            : output stream ready
//     busy               : high while the FSM is in READ (state visibility)
//     burst_cnt          : reads issued in the current burst
//   Handshake: a word moves on every cycle with m_valid && m_ready; while
//   m_valid && !m_ready, m_valid stays high and m_data is held.
module fifo_burst_rd
   import fifo_rd_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int USEDW_W    = 8,
   parameter int BURST_LEN  = 128,
   parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
`ifdef FIFO_RD_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [DATA_W-1:0]  fifo_q,
   input  logic               fifo_empty,
   input  logic               fifo_full,
   input  logic [USEDW_W-1:0] fifo_usedw,
   output logic               fifo_rdreq,
   output logic [DATA_W-1:0]  m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               busy,
   output logic [8:0]         burst_cnt
);

   localparam int     OW         = $clog2(OBUF_DEPTH) + 1;
   localparam level_t BLEN       = level_t'(BURST_LEN);
   localparam logic [OW:0] CREDIT_MAX = (OW + 1)'(OBUF_DEPTH - 2);

   rd_state_e     state;
   rd_state_e     state_nxt;
   level_t        level;
   level_t        blen;
   logic          inflight;
   logic [OW-1:0] occ;
   logic [OW:0]   committed;
   logic          credit_ok;
   logic          start_full;

   assign level     = fifo_level(fifo_full, fifo_usedw);
   assign busy      = (state == READ);

   // A word already requested (inflight) will land in the buffer next cycle,
   // so it counts against the space just like a stored word.
   assign committed = {1'b0, occ} + {{OW{1'b0}}, inflight};
   assign credit_ok = (committed <= CREDIT_MAX);

`ifdef FIFO_RD_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

   logic [15:0] idle_cnt;
   level_t      blen_q;
   logic        residue;
   logic        timeout_hit;

   assign blen        = blen_q;
   assign residue     = (state == IDLE) && (level != '0) && (level < BLEN);
   assign timeout_hit = residue && (idle_cnt == TO_LIM);
`else
   assign blen = BLEN;
`endif

   always_comb begin
      state_nxt  = state;
      start_full = 1'b0;
      fifo_rdreq = 1'b0;
      case (state)
         IDLE: begin
            if (level >= BLEN) begin
               state_nxt  = READ;
               start_full = 1'b1;
            end
`ifdef FIFO_RD_TIMEOUT_EN
            else if (timeout_hit) begin
               state_nxt = READ;
            end
`endif
         end
         READ: begin
            fifo_rdreq = !fifo_empty && (burst_cnt < blen) && credit_ok;
            // Leave on the cycle the last read of the burst is issued.
            if (fifo_rdreq && (burst_cnt == blen - 9'd1)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         inflight  <= 1'b0;
         burst_cnt <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_rdreq;
         if ((state == IDLE) && (state_nxt == READ)) begin
            burst_cnt <= '0;
         end else if (fifo_rdreq) begin
            burst_cnt <= burst_cnt + 9'd1;
         end
      end
   end

`ifdef FIFO_RD_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idle_cnt <= '0;
         blen_q   <= BLEN;
      end else begin
         if (residue && !timeout_hit) begin
            idle_cnt <= idle_cnt + 16'd1;
         end else begin
            idle_cnt <= '0;
         end
         // A partial burst drains exactly the level seen when it started.
         if (start_full) begin
            blen_q <= BLEN;
         end else if (timeout_hit) begin
            blen_q <= level;
         end
      end
   end
`endif

   rd_skid_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (OBUF_DEPTH)
   ) u_obuf (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .push       (inflight),
      .push_data  (fifo_q),
      .pop        (m_ready),
      .occ        (occ),
      .head_valid (m_valid),
      .head_data  (m_data)
   );

endmodule
